// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: bitwise 8-op gate on WIDTH-bit operands, STAGES-deep valid/ready pipeline, saturating delivery counter
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    producer handshake; in_a, in_b operands; in_op operation select
//   out_valid/out_ready  consumer handshake; out_y result
//   cnt_clr              synchronous clear of out_count (wins over an increment)
//   out_count            number of delivered results, saturating at 2^CNT_W-1
//   out_zero, out_parity result == 0 and XOR-reduction of result (only with LOGIC_GATE_PIPE_STATUS_EN)
// Optional feature macro: LOGIC_GATE_PIPE_STATUS_EN
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] out_count
`ifdef LOGIC_GATE_PIPE_STATUS_EN
    ,
    output logic             out_zero,
    output logic             out_parity
`endif
);
`ifdef LOGIC_GATE_PIPE_STATUS_EN
    // Flags ride in the two bits above the result so they stay aligned with out_y
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH;
`endif
    logic [WIDTH-1:0]          res;
    logic [DW-1:0]             din;
    logic [STAGES:1]           v;
    logic [STAGES:1]           r;
    logic [STAGES:1][DW-1:0]   d;
    logic [STAGES:0]           vin;
    logic [STAGES:0][DW-1:0]   dp;
    always_comb begin
        res = '0;
        case (in_op)
            3'b000:  res = in_a & in_b;
            3'b001:  res = in_a | in_b;
            3'b010:  res = in_a ^ in_b;
            3'b011:  res = ~(in_a & in_b);
            3'b100:  res = ~(in_a | in_b);
            3'b101:  res = ~(in_a ^ in_b);
            3'b110:  res = ~in_a;
            default: res = in_a;
        endcase
    end
`ifdef LOGIC_GATE_PIPE_STATUS_EN
    assign din = {~|res, ^res, res};
`else
    assign din = res;
`endif
    // Index 0 is the producer side, so stage k always loads from index k-1
    assign vin = {v, in_valid};
    assign dp  = {d, din};
    // Walk from the output back: a stage may load if it is empty or everything below it can move
    always_comb begin : p_ready
        logic down;
        down = out_ready;
        r = '0;
        for (int k = STAGES; k >= 1; k--) begin
            down = !v[k] || down;
            r[k] = down;
        end
    end
    // Data only loads with a valid beat, so X on idle inputs never reaches the stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            d <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (r[k]) begin
                    v[k] <= vin[k-1];
                    if (vin[k-1]) d[k] <= dp[k-1];
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_count <= '0;
        else if (cnt_clr) out_count <= '0;
        else if (out_valid && out_ready && !(&out_count)) out_count <= out_count + 1'b1;
    end
    assign in_ready  = r[1];
    assign out_valid = v[STAGES];
    assign out_y     = d[STAGES][WIDTH-1:0];
`ifdef LOGIC_GATE_PIPE_STATUS_EN
    assign out_zero   = d[STAGES][WIDTH+1];
    assign out_parity = d[STAGES][WIDTH];
`endif
endmodule
